// File: rtl/arith_pkg.sv
// Shared definitions for the multiplier-side arithmetic blocks: default
// datapath widths and the accumulator control state encoding.
package arith_pkg;

   // Default widths: product matches the 8x8 multiplier output, the
   // accumulator leaves headroom for a few hundred full-scale products.
   localparam int DEF_PROD_W = 16;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_e;

endpackage : arith_pkg

// File: rtl/prod_accumulator.sv
// Product accumulator: sums a programmed number of unsigned products taken
// over a valid/ready stream, then holds the sum until the consumer acks it.
// The accumulator wraps modulo 2^ACC_W, and a sticky flag records any carry
// out of the top bit during the run.
module prod_accumulator
   import arith_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W,   // must be >= PROD_W
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ack,
   output logic              overflow,
   output logic              busy
);

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic             ovf_q,   ovf_d;
   logic [LEN_W-1:0] cnt_q,   cnt_d;

   // One extra bit on the adder captures the carry out of ACC_W.
   logic [ACC_W:0]   prod_ext;
   logic [ACC_W:0]   sum_ext;
   logic             xfer;

   // Handshake and status outputs decode straight from the state register.
   assign prod_ready = (state_q == ACCUM);
   assign acc_valid  = (state_q == DONE);
   assign busy       = (state_q == ACCUM) || (state_q == DONE);
   assign acc_out    = acc_q;
   assign overflow   = ovf_q;

   assign xfer     = prod_valid && prod_ready;
   // Products are unsigned: zero-extend, never sign-extend.
   assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
   assign sum_ext  = {1'b0, acc_q} + prod_ext;

   // Next-state, accumulator, overflow and term-counter update.
   always_comb begin
      // NOTE: every target gets a hold default first so no path leaves it
      // unassigned; that is what keeps this block free of inferred latches.
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = len;
               // An empty run goes straight to DONE with a zero result.
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end

         ACCUM: begin
            if (xfer) begin
               acc_d = sum_ext[ACC_W-1:0];
               if (sum_ext[ACC_W]) begin
                  ovf_d = 1'b1;
               end
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            // start is deliberately ignored here, even alongside acc_ack.
            if (acc_ack) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops any partial sum immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge
         // values regardless of statement order.
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule : prod_accumulator

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator. Two instances share every input:
// one at the default 24-bit accumulator, one at 17 bits so that wrap and the
// sticky overflow flag are exercised by realistic products. Expected results
// come from the plain arithmetic total of each run.
module tb_prod_accumulator;

   localparam int PW   = 16;
   localparam int LW   = 8;
   localparam int AW_A = 24;
   localparam int AW_B = 17;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [LW-1:0]   len = '0;
   logic [PW-1:0]   prod_in = '0;
   logic            prod_valid = 1'b0;
   logic            acc_ack = 1'b0;

   logic            prod_ready_a, acc_valid_a, overflow_a, busy_a;
   logic [AW_A-1:0] acc_out_a;
   logic            prod_ready_b, acc_valid_b, overflow_b, busy_b;
   logic [AW_B-1:0] acc_out_b;

   int total = 0;
   int bad   = 0;

   logic [PW-1:0] prod_q[$];

   always #5 clk = ~clk;

   prod_accumulator #(.PROD_W(PW), .ACC_W(AW_A), .LEN_W(LW)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready_a),
      .acc_out    (acc_out_a),
      .acc_valid  (acc_valid_a),
      .acc_ack    (acc_ack),
      .overflow   (overflow_a),
      .busy       (busy_a)
   );

   prod_accumulator #(.PROD_W(PW), .ACC_W(AW_B), .LEN_W(LW)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready_b),
      .acc_out    (acc_out_b),
      .acc_valid  (acc_valid_b),
      .acc_ack    (acc_ack),
      .overflow   (overflow_b),
      .busy       (busy_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Result of a run whose true (unbounded) total is sum: wrapped value and
   // whether the total ever crossed 2^W (sticky carry).
   task automatic check_result(input string tag, input longint unsigned sum);
      longint unsigned lim_a = 64'd1 << AW_A;
      longint unsigned lim_b = 64'd1 << AW_B;
      check({tag, "_acc24"}, 64'(acc_out_a), sum % lim_a);
      check({tag, "_ovf24"}, 64'(overflow_a), 64'(sum >= lim_a));
      check({tag, "_acc17"}, 64'(acc_out_b), sum % lim_b);
      check({tag, "_ovf17"}, 64'(overflow_b), 64'(sum >= lim_b));
   endtask

   task automatic check_ctrl(input string tag, input bit ready, input bit valid, input bit bsy);
      check({tag, "_ready"}, 64'({prod_ready_a, prod_ready_b}), 64'({ready, ready}));
      check({tag, "_valid"}, 64'({acc_valid_a, acc_valid_b}), 64'({valid, valid}));
      check({tag, "_busy"},  64'({busy_a, busy_b}), 64'({bsy, bsy}));
   endtask

   // One complete run using the products in prod_q. gap<0 means random gaps.
   task automatic run(input string tag, input int gap, input int hold, input bit ack_with_start);
      longint unsigned sum = 0;
      int n = prod_q.size();
      start = 1'b1;
      len   = LW'(n);
      step();
      start = 1'b0;
      len   = LW'($urandom);          // must not affect the run in progress
      if (n == 0) begin
         check_ctrl({tag, "_empty"}, 1'b0, 1'b1, 1'b1);
      end else begin
         check_ctrl({tag, "_go"}, 1'b1, 1'b0, 1'b1);
         check_result({tag, "_clr"}, 0);
         for (int i = 0; i < n; i++) begin
            int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int j = 0; j < g; j++) begin
               prod_valid = 1'b0;
               prod_in    = PW'($urandom);
               step();
               check_ctrl({tag, "_gap"}, 1'b1, 1'b0, 1'b1);
            end
            prod_valid = 1'b1;
            prod_in    = prod_q[i];
            sum       += longint'(prod_q[i]);
            step();
            prod_valid = 1'b0;
            prod_in    = PW'($urandom);
            if (i < n - 1) begin
               check_ctrl({tag, "_mid"}, 1'b1, 1'b0, 1'b1);
            end
         end
         check_ctrl({tag, "_done"}, 1'b0, 1'b1, 1'b1);
      end
      check_result({tag, "_res"}, sum);
      for (int h = 0; h < hold; h++) begin
         prod_valid = 1'b1;             // offered products are refused in DONE
         step();
         prod_valid = 1'b0;
         check_ctrl({tag, "_hold"}, 1'b0, 1'b1, 1'b1);
         check_result({tag, "_hold"}, sum);
      end
      acc_ack = 1'b1;
      if (ack_with_start) begin
         start = 1'b1;
         len   = LW'(3);
      end
      step();
      acc_ack = 1'b0;
      start   = 1'b0;
      check_ctrl({tag, "_ack"}, 1'b0, 1'b0, 1'b0);
      check_result({tag, "_idle"}, sum);
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check_ctrl("reset", 1'b0, 1'b0, 1'b0);
      check_result("reset", 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check_ctrl("idle", 1'b0, 1'b0, 1'b0);

      // Four-term sum, back to back: 84220 = 0x148FC.
      prod_q = '{16'd72, 16'd1024, 16'd37714, 16'd45410};
      run("four", 0, 0, 1'b0);

      // Same terms with two idle cycles before each one.
      run("gaps", 2, 0, 1'b0);

      // Wraps the 17-bit instance: 195075 mod 131072 = 64003 with overflow.
      prod_q = '{16'hFE01, 16'hFE01, 16'hFE01};
      run("ovf", 0, 0, 1'b0);
      check("ovf_wrap17", 64'(acc_out_b), 64'd64003);

      // Next start clears overflow and accumulator.
      prod_q = '{16'd5};
      run("after_ovf", 0, 0, 1'b0);

      // Empty run.
      prod_q = {};
      run("len0", 0, 0, 1'b0);

      // Hold five cycles in DONE, then ack together with start.
      prod_q = '{16'd300, 16'd7};
      run("hold", 0, 5, 1'b1);
      // Fresh start in the following cycle proceeds.
      prod_q = '{16'd1000};
      run("fresh", 0, 0, 1'b0);

      // Reset after 2 of 4 terms, asserted between clock edges.
      start = 1'b1;
      len   = LW'(4);
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         prod_valid = 1'b1;
         prod_in    = 16'd500;
         step();
      end
      prod_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_ctrl("rst_mid", 1'b0, 1'b0, 1'b0);
      check_result("rst_mid", 0);
      step();
      rst_n = 1'b1;
      step();
      check_ctrl("rst_after", 1'b0, 1'b0, 1'b0);
      prod_q = '{16'd72};
      run("rst_rerun", 0, 0, 1'b0);

      // Randomised runs, biased towards full-scale products.
      for (int r = 0; r < 30; r++) begin
         int n = $urandom_range(0, 6);
         prod_q = {};
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) prod_q.push_back(16'hFFFF);
            else prod_q.push_back(PW'($urandom));
         end
         run($sformatf("rnd%0d", r), -1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_prod_accumulator

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 array multiplier.
- Consumes a stream of 16-bit unsigned products over a valid/ready handshake and sums a programmed number of them into a wider accumulator.
- Presents the result with a hold-until-acknowledged handshake.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PROD_W, 16, width of incoming product (matches the multiplier output width).
- ACC_W, 24, accumulator width; must be >= PROD_W.
- LEN_W, 8, width of the term-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a new accumulation; honoured only in IDLE.
- len  input  LEN_W  number of products to sum; sampled on an accepted start.
- prod_in  input  PROD_W  unsigned product from the multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block accepts prod_in this cycle.
- acc_out  output  ACC_W  accumulated sum.
- acc_valid  output  1  acc_out holds the final result.
- acc_ack  input  1  consumer takes the result.
- overflow  output  1  sticky flag: carry out of ACC_W occurred during the current run.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc_out=0, remaining-count=0, prod_ready=0, acc_valid=0, overflow=0, busy=0.
- States: IDLE, ACCUM, DONE. All outputs are registered, except prod_ready, acc_valid and busy, which decode directly from state.
- IDLE, start=1, len!=0: clear acc_out and overflow, load count=len, go to ACCUM.
- IDLE, start=1, len==0: clear acc_out and overflow, go directly to DONE, so acc_valid=1 with acc_out=0 on the next cycle.
- IDLE, start=0: hold; acc_out keeps the last result.
- ACCUM:
  - prod_ready=1.
  - Transfer occurs when prod_valid && prod_ready.
  - On transfer: acc_out <= acc_out + zero-extended prod_in, truncated to ACC_W bits. If the add produces a carry out, overflow <= 1 (sticky until the next accepted start). Count decrements.
  - When the transfer consumes the last term (count==1), go to DONE.
  - No transfer: hold all state; gaps in prod_valid are legal.
- DONE:
  - prod_ready=0; acc_valid=1.
  - acc_out and overflow are stable and held until acc_ack=1, then go to IDLE on the next edge.
- Latency: acc_valid asserts on the cycle after the last product is transferred.
- start outside IDLE is ignored, including start coincident with acc_ack in DONE. A new run needs start in a later cycle, once the block is in IDLE.
- Throughput: one product per cycle in ACCUM.
- Arithmetic: unsigned only; products are zero-extended, never sign-extended. Wrap modulo 2^ACC_W is combined with the sticky overflow flag.
- Reset mid-operation: immediate return to reset values. Any partial sum is lost; no result is emitted.
- len is sampled only on an accepted start. Later changes to len have no effect on the run in progress.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum (IDLE/ACCUM/DONE);
  - the default width constants: PROD_W=16, ACC_W=24, LEN_W=8.
- No sub-module. The down-counter and adder are inline; a separate module adds nothing at this size.

Test Plan:
- Four-term sum: start with len=4, then products 72, 1024, 37714, 45410 (9*8, 32*32, 0xDA*0xAD, 0xBE*0xEF) on consecutive cycles -> acc_valid one cycle after the 4th transfer, acc_out=84220 (0x148FC), overflow=0.
- Same four products with prod_valid low for 2 cycles between each term -> same result 0x148FC. prod_ready stays 1 throughout ACCUM; no double counting.
- Overflow: ACC_W=17, len=3, three products of 0xFE01 -> acc_out=64003 (195075 mod 131072), overflow=1. A subsequent start clears overflow and acc_out.
- len=0: start with len=0 -> acc_valid=1 with acc_out=0 on the next cycle. prod_ready never asserts.
- Hold and handshake in DONE:
  - Hold acc_ack=0 for 5 cycles in DONE -> acc_out stable, acc_valid stays high.
  - acc_ack=1 together with start=1 -> IDLE, start ignored, busy=0.
  - A fresh start one cycle later -> the new run proceeds.
- Reset mid-run: assert rst_n=0 asynchronously after 2 of 4 terms -> all outputs return to 0 immediately, without waiting for a clock edge. After release, the block sits in IDLE and a new len=1 run with product 72 gives acc_out=72.
